// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: condition check, ALU, NZCV flags, branch target, shadow squash
module execute_stage #(
    parameter int BR_SHADOW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] dataA_in,
    input  logic [31:0] dataB_in,
    input  logic [31:0] br_se_in,
    input  logic [31:0] ls_se_in,
    input  logic [31:0] alu_se_in,
    input  logic [3:0]  rd_in,
    input  logic [10:0] sign_in,
    input  logic [3:0]  br_cond_in,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        mem_to_reg_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out,
    output logic [3:0]  flags_out,
    output logic        valid_out
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_MVN = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;
    localparam logic [1:0] SHADOW_LOAD = 2'(BR_SHADOW);

    logic        c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg;
    logic        c_alu_src, c_imm_sel, c_branch, c_set_flags;
    logic [2:0]  c_alu_op;

    assign c_reg_write  = sign_in[0];
    assign c_mem_read   = sign_in[1];
    assign c_mem_write  = sign_in[2];
    assign c_mem_to_reg = sign_in[3];
    assign c_alu_src    = sign_in[4];
    assign c_imm_sel    = sign_in[5];
    assign c_branch     = sign_in[6];
    assign c_set_flags  = sign_in[7];
    assign c_alu_op     = sign_in[10:8];

    logic [31:0] alu_result_q, store_data_q, branch_target_q;
    logic [3:0]  rd_q, flags_q, flags_d;
    logic        reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic        branch_taken_q, valid_q;
    logic [1:0]  shadow_q, shadow_d;

    logic        flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    logic        cond_pass, exec, advance;
    logic [31:0] op_b, alu_res;
    logic [32:0] add_w, sub_w;
    logic        arith, res_c, res_v;

    // Condition field evaluated against the architectural flags register
    always_comb begin
        cond_pass = 1'b0;
        case (br_cond_in)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign advance = flush || !stall;
    assign exec    = cond_pass && (shadow_q == 2'd0) && !flush;
    assign op_b    = c_alu_src ? (c_imm_sel ? ls_se_in : alu_se_in) : dataB_in;
    assign add_w   = {1'b0, dataA_in} + {1'b0, op_b};
    assign sub_w   = {1'b0, dataA_in} + {1'b0, ~op_b} + 33'd1;

    // ALU result plus carry/overflow for the arithmetic ops
    always_comb begin
        alu_res = add_w[31:0];
        res_c   = add_w[32];
        res_v   = (dataA_in[31] == op_b[31]) && (add_w[31] != dataA_in[31]);
        arith   = 1'b0;
        case (c_alu_op)
            OP_ADD: arith = 1'b1;
            OP_SUB, OP_CMP: begin
                alu_res = sub_w[31:0];
                res_c   = sub_w[32];
                res_v   = (dataA_in[31] != op_b[31]) && (sub_w[31] != dataA_in[31]);
                arith   = 1'b1;
            end
            OP_AND:  alu_res = dataA_in & op_b;
            OP_ORR:  alu_res = dataA_in | op_b;
            OP_EOR:  alu_res = dataA_in ^ op_b;
            OP_MOV:  alu_res = op_b;
            OP_MVN:  alu_res = ~op_b;
            default: alu_res = add_w[31:0];
        endcase
    end

    // Next flags: logical ops keep C and V; squashed or non-setting ops keep all
    always_comb begin
        flags_d = flags_q;
        if (exec && (c_set_flags || c_alu_op == OP_CMP)) begin
            flags_d[3] = alu_res[31];
            flags_d[2] = (alu_res == 32'd0);
            if (arith) begin
                flags_d[1] = res_c;
                flags_d[0] = res_v;
            end
        end
    end

    // Shadow counter: flush clears, taken branch reloads, otherwise count down
    always_comb begin
        shadow_d = shadow_q;
        if (flush)
            shadow_d = 2'd0;
        else if (exec && c_branch)
            shadow_d = SHADOW_LOAD;
        else if (shadow_q != 2'd0)
            shadow_d = shadow_q - 2'd1;
    end

    // EX/MEM register bank; holds on stall unless flushed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_q    <= 32'd0;
            store_data_q    <= 32'd0;
            branch_target_q <= 32'd0;
            rd_q            <= 4'd0;
            flags_q         <= 4'd0;
            reg_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            branch_taken_q  <= 1'b0;
            valid_q         <= 1'b0;
            shadow_q        <= 2'd0;
        end else if (advance) begin
            alu_result_q    <= alu_res;
            store_data_q    <= dataB_in;
            branch_target_q <= pc_in + {br_se_in[29:0], 2'b00};
            rd_q            <= rd_in;
            flags_q         <= flags_d;
            reg_write_q     <= exec && c_reg_write && (c_alu_op != OP_CMP);
            mem_read_q      <= exec && c_mem_read;
            mem_write_q     <= exec && c_mem_write;
            mem_to_reg_q    <= exec && c_mem_to_reg;
            branch_taken_q  <= exec && c_branch;
            valid_q         <= exec;
            shadow_q        <= shadow_d;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign branch_target_out = branch_target_q;
    assign rd_out            = rd_q;
    assign flags_out         = flags_q;
    assign reg_write_out     = reg_write_q;
    assign mem_read_out      = mem_read_q;
    assign mem_write_out     = mem_write_q;
    assign mem_to_reg_out    = mem_to_reg_q;
    assign branch_taken_out  = branch_taken_q;
    assign valid_out         = valid_q;
endmodule
